sdio_xfer_ctrl: RTL and testbench
=================================

Name: sdio_xfer_ctrl

Overview:
Transfer sequencer that sits between the uDMA SDIO register/config layer and the SDIO TX/RX engine. It takes one command/data request, clears engine status, launches the command, waits for end-of-transfer with a timeout, and retries on error. For write transfers it can then poll the card with CMD13 until the card reports ready-for-data in TRAN state. Exactly one transfer is in flight; completion is reported with a done pulse and a latched result code.

Parameters:
MAX_RETRY, 3, additional attempts after a failed first attempt (0 = no retry)
POLL_MAX, 1023, maximum number of CMD13 polls before declaring busy-timeout
TIMEOUT_CYCLES, 1048576, clk_i cycles allowed between cmd_start_o and eot_i

Ports:
clk_i  in  1  system clock (SD clock source for the engine)
rst_i  in  1  synchronous reset, active-high
req_valid_i  in  1  request valid
req_ready_o  out  1  high only in IDLE
req_op_i  in  6  command index
req_arg_i  in  32  command argument
req_rsp_type_i  in  3  response type
req_data_en_i  in  1  request has a data phase
req_rwn_i  in  1  1 = read, 0 = write
req_quad_i  in  1  4-bit data bus
req_block_size_i  in  10  block size field, passed through
req_block_num_i  in  8  block count field, passed through
req_poll_en_i  in  1  poll with CMD13 after a successful write
req_rca_i  in  16  card RCA used as the CMD13 argument
clr_stat_o  out  1  1-cycle pulse to the engine status clear
cmd_start_o  out  1  1-cycle engine start pulse
cmd_op_o  out  6  engine op
cmd_arg_o  out  32  engine arg
cmd_rsp_type_o  out  3  engine response type
data_en_o / data_rwn_o / data_quad_o  out  1 each  engine data controls
data_block_size_o  out  10  engine block size
data_block_num_o  out  8  engine block count
eot_i  in  1  engine end-of-transfer
status_i  in  16  engine status: [13:8] data status, [5:0] cmd status
rsp_data_i  in  32  engine response word 0 (R1 card status)
done_o  out  1  1-cycle completion pulse
result_o  out  3  0 OK, 1 CMD/DATA error, 2 EOT timeout, 3 busy-poll timeout; holds until next done
retries_o  out  3  retries consumed by the last transfer
busy_o  out  1  high whenever not IDLE

Behaviour:
- Reset state: IDLE. All outputs are 0 except req_ready_o, which is 1. Counters and latched request fields are cleared.
- Reset mid-operation returns to IDLE in one cycle. No start or done pulse is emitted after reset.
- Request acceptance: a request is accepted when req_valid_i && req_ready_o. All req_* fields are latched at acceptance.
- Engine outputs are driven from the latched fields. In the POLL states they are forced to: op = 13, arg = {rca, 16'h0}, rsp_type = 3'h1, data_en = 0.
- States:
  - IDLE: on accept, go to CLR. Clear the attempt counter.
  - CLR: clr_stat_o = 1 for one cycle, then go to START.
  - START: cmd_start_o = 1 for one cycle. Load the timeout counter with TIMEOUT_CYCLES-1. Go to WAIT.
  - WAIT: decrement the counter each cycle.
    - eot_i seen: go to CHECK.
    - Counter reaches 0 without eot_i: result = 2, go to DONE.
    - If eot_i and counter==0 occur in the same cycle, eot_i wins.
  - CHECK: err = |status_i[13:8] | |status_i[5:0].
    - err and attempts < MAX_RETRY: increment attempts, go to CLR.
    - err and attempts == MAX_RETRY: result = 1, go to DONE.
    - No error, and poll_en && data_en && !rwn: clear the poll counter, go to PCLR.
    - No error otherwise: result = 0, go to DONE.
  - PCLR / PSTART / PWAIT: same as CLR / START / WAIT using the CMD13 fields. PWAIT timeout gives result = 2.
  - PCHECK:
    - Status error: result = 1, go to DONE. Poll errors are not retried.
    - rsp_data_i[8] == 1 and rsp_data_i[12:9] == 4: result = 0, go to DONE.
    - Otherwise, if the poll counter == POLL_MAX-1: result = 3, go to DONE.
    - Otherwise: increment the poll counter, go to PCLR.
  - DONE: done_o = 1 for one cycle. Update result_o and retries_o. Go to IDLE.
- Latency, error-free non-polled transfer: cmd_start_o is asserted 2 cycles after acceptance; done_o is asserted 2 cycles after eot_i.
- eot_i is ignored outside WAIT and PWAIT. status_i and rsp_data_i are sampled only in CHECK and PCHECK.
- Counter widths:
  - Timeout counter: $clog2(TIMEOUT_CYCLES) bits.
  - Poll counter: $clog2(POLL_MAX+1) bits.
  - Attempt counter: 3 bits.
  - No counter may wrap. Each counter stops at its terminal value.

Test Plan:
- CMD0 with no data, eot_i 10 cycles after start and status 0 → clr at T+1, start at T+2, done 2 cycles after eot; result 0, retries 0.
- Read of 4 blocks: status 0x0100 on the first two attempts, 0 on the third → 3 clr/start pairs; result 0, retries 2.
- Persistent status 0x0001 with MAX_RETRY = 3 → exactly 4 starts; result 1, retries 3.
- TIMEOUT_CYCLES = 16 and eot_i never asserted → done 17 cycles after start; result 2.
- Write with poll_en and rca = 0x1234: rsp 0x0000_0E00 twice, then 0x0000_0900 → CMD13 is issued 3 times with arg 0x1234_0000; result 0.
- Polled write with POLL_MAX = 4, rsp always 0x0000_0E00 → 4 CMD13s; result 3. Then assert rst_i during WAIT of the next transfer → IDLE next cycle, req_ready_o = 1, no done pulse.

Source files
------------

// File: rtl/sdio_xfer_ctrl_if.sv
// sdio_xfer_ctrl_if: request bus from the config layer plus command/data bus to the SDIO engine.
// Ports: req_* (request + ready), clr_stat/cmd_*/data_* (engine controls), eot/status/rsp (engine
// results), done/result/retries/busy (completion). slave = sequencer view, master = surroundings.
interface sdio_xfer_ctrl_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [5:0]  req_op_i;
  logic [31:0] req_arg_i;
  logic [2:0]  req_rsp_type_i;
  logic        req_data_en_i;
  logic        req_rwn_i;
  logic        req_quad_i;
  logic [9:0]  req_block_size_i;
  logic [7:0]  req_block_num_i;
  logic        req_poll_en_i;
  logic [15:0] req_rca_i;

  logic        clr_stat_o;
  logic        cmd_start_o;
  logic [5:0]  cmd_op_o;
  logic [31:0] cmd_arg_o;
  logic [2:0]  cmd_rsp_type_o;
  logic        data_en_o;
  logic        data_rwn_o;
  logic        data_quad_o;
  logic [9:0]  data_block_size_o;
  logic [7:0]  data_block_num_o;
  logic        eot_i;
  logic [15:0] status_i;
  logic [31:0] rsp_data_i;

  logic        done_o;
  logic [2:0]  result_o;
  logic [2:0]  retries_o;
  logic        busy_o;

  modport slave (
    input  req_valid_i, req_op_i, req_arg_i, req_rsp_type_i, req_data_en_i, req_rwn_i,
           req_quad_i, req_block_size_i, req_block_num_i, req_poll_en_i, req_rca_i,
           eot_i, status_i, rsp_data_i,
    output req_ready_o, clr_stat_o, cmd_start_o, cmd_op_o, cmd_arg_o, cmd_rsp_type_o,
           data_en_o, data_rwn_o, data_quad_o, data_block_size_o, data_block_num_o,
           done_o, result_o, retries_o, busy_o
  );

  modport master (
    output req_valid_i, req_op_i, req_arg_i, req_rsp_type_i, req_data_en_i, req_rwn_i,
           req_quad_i, req_block_size_i, req_block_num_i, req_poll_en_i, req_rca_i,
           eot_i, status_i, rsp_data_i,
    input  req_ready_o, clr_stat_o, cmd_start_o, cmd_op_o, cmd_arg_o, cmd_rsp_type_o,
           data_en_o, data_rwn_o, data_quad_o, data_block_size_o, data_block_num_o,
           done_o, result_o, retries_o, busy_o
  );
endinterface

// File: rtl/sdio_xfer_ctrl.sv
// sdio_xfer_ctrl: one-at-a-time SDIO transfer sequencer (clear, start, wait eot w/ timeout, retry,
// optional CMD13 busy polling after writes). Ports: clk_i, rst_i (sync, active-high), bus (slave).
// Latency: start 2 cycles after accept, done 2 cycles after eot; req_ready_o only in IDLE.
module sdio_xfer_ctrl #(
  parameter int MAX_RETRY      = 3,
  parameter int POLL_MAX       = 1023,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input logic             clk_i,
  input logic             rst_i,
  sdio_xfer_ctrl_if.slave bus
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int PW = (POLL_MAX > 0) ? $clog2(POLL_MAX + 1) : 1;
  localparam logic [TW-1:0] TMO_LOAD   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_MAX - 1);
  localparam logic [2:0]    RETRY_LAST = 3'(MAX_RETRY);

  localparam logic [2:0] RES_OK   = 3'd0;
  localparam logic [2:0] RES_ERR  = 3'd1;
  localparam logic [2:0] RES_TMO  = 3'd2;
  localparam logic [2:0] RES_BUSY = 3'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_START, S_WAIT, S_CHECK,
    S_PCLR, S_PSTART, S_PWAIT, S_PCHECK, S_DONE
  } state_e;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] arg;
    logic [2:0]  rsp_type;
    logic        data_en;
    logic        rwn;
    logic        quad;
    logic [9:0]  block_size;
    logic [7:0]  block_num;
    logic        poll_en;
    logic [15:0] rca;
  } req_t;

  state_e        state_q, state_d;
  req_t          req_q, req_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [2:0]    att_q, att_d;
  logic [2:0]    result_q, result_d;
  logic [2:0]    retries_q, retries_d;

  logic clr_stat, cmd_start, done;
  logic status_err, card_ready, in_poll;

  assign status_err = (|bus.status_i[13:8]) | (|bus.status_i[5:0]);
  // R1: READY_FOR_DATA set and CURRENT_STATE == TRAN
  assign card_ready = bus.rsp_data_i[8] && (bus.rsp_data_i[12:9] == 4'd4);
  assign in_poll    = (state_q == S_PCLR) || (state_q == S_PSTART) ||
                      (state_q == S_PWAIT) || (state_q == S_PCHECK);

  logic unused_bits;
  assign unused_bits = ^{bus.status_i[15:14], bus.status_i[7:6],
                         bus.rsp_data_i[31:13], bus.rsp_data_i[7:0]};

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    tmo_d     = tmo_q;
    poll_d    = poll_q;
    att_d     = att_q;
    result_d  = result_q;
    retries_d = retries_q;
    clr_stat  = 1'b0;
    cmd_start = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid_i) begin
          req_d.op         = bus.req_op_i;
          req_d.arg        = bus.req_arg_i;
          req_d.rsp_type   = bus.req_rsp_type_i;
          req_d.data_en    = bus.req_data_en_i;
          req_d.rwn        = bus.req_rwn_i;
          req_d.quad       = bus.req_quad_i;
          req_d.block_size = bus.req_block_size_i;
          req_d.block_num  = bus.req_block_num_i;
          req_d.poll_en    = bus.req_poll_en_i;
          req_d.rca        = bus.req_rca_i;
          att_d            = 3'd0;
          state_d          = S_CLR;
        end
      end
      S_CLR, S_PCLR: begin
        clr_stat = 1'b1;
        state_d  = (state_q == S_CLR) ? S_START : S_PSTART;
      end
      S_START, S_PSTART: begin
        cmd_start = 1'b1;
        tmo_d     = TMO_LOAD;
        state_d   = (state_q == S_START) ? S_WAIT : S_PWAIT;
      end
      S_WAIT, S_PWAIT: begin
        // eot on the terminal count still counts as a completed command
        if (bus.eot_i) begin
          state_d = (state_q == S_WAIT) ? S_CHECK : S_PCHECK;
        end else if (tmo_q == '0) begin
          result_d  = RES_TMO;
          retries_d = att_q;
          state_d   = S_DONE;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end
      S_CHECK: begin
        if (status_err) begin
          if (att_q < RETRY_LAST) begin
            att_d   = att_q + 3'd1;
            state_d = S_CLR;
          end else begin
            result_d  = RES_ERR;
            retries_d = att_q;
            state_d   = S_DONE;
          end
        end else if (req_q.poll_en && req_q.data_en && !req_q.rwn) begin
          poll_d  = '0;
          state_d = S_PCLR;
        end else begin
          result_d  = RES_OK;
          retries_d = att_q;
          state_d   = S_DONE;
        end
      end
      S_PCHECK: begin
        if (status_err) begin
          result_d  = RES_ERR;
          retries_d = att_q;
          state_d   = S_DONE;
        end else if (card_ready) begin
          result_d  = RES_OK;
          retries_d = att_q;
          state_d   = S_DONE;
        end else if (poll_q == POLL_LAST) begin
          result_d  = RES_BUSY;
          retries_d = att_q;
          state_d   = S_DONE;
        end else begin
          poll_d  = poll_q + PW'(1);
          state_d = S_PCLR;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      req_q     <= '0;
      tmo_q     <= '0;
      poll_q    <= '0;
      att_q     <= '0;
      result_q  <= '0;
      retries_q <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      tmo_q     <= tmo_d;
      poll_q    <= poll_d;
      att_q     <= att_d;
      result_q  <= result_d;
      retries_q <= retries_d;
    end
  end

  assign bus.req_ready_o       = (state_q == S_IDLE);
  assign bus.busy_o            = (state_q != S_IDLE);
  assign bus.clr_stat_o        = clr_stat;
  assign bus.cmd_start_o       = cmd_start;
  assign bus.done_o            = done;
  assign bus.result_o          = result_q;
  assign bus.retries_o         = retries_q;
  // CMD13 SEND_STATUS overrides the latched command while polling
  assign bus.cmd_op_o          = in_poll ? 6'd13 : req_q.op;
  assign bus.cmd_arg_o         = in_poll ? {req_q.rca, 16'h0000} : req_q.arg;
  assign bus.cmd_rsp_type_o    = in_poll ? 3'h1 : req_q.rsp_type;
  assign bus.data_en_o         = in_poll ? 1'b0 : req_q.data_en;
  assign bus.data_rwn_o        = req_q.rwn;
  assign bus.data_quad_o       = req_q.quad;
  assign bus.data_block_size_o = req_q.block_size;
  assign bus.data_block_num_o  = req_q.block_num;

endmodule

// File: tb/tb_sdio_xfer_ctrl.sv
module tb_sdio_xfer_ctrl;
  localparam int MAX_RETRY = 3;
  localparam int POLL_MAX  = 4;
  localparam int TMO       = 16;
  localparam int NSC       = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdio_xfer_ctrl_if bus ();
  sdio_xfer_ctrl #(.MAX_RETRY(MAX_RETRY), .POLL_MAX(POLL_MAX), .TIMEOUT_CYCLES(TMO))
    dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  // engine script: per issued command, eot delay after start (0 = never), status, response
  int          sc_dly [NSC];
  logic [15:0] sc_st  [NSC];
  logic [31:0] sc_rsp [NSC];

  logic [5:0]  o_op[$];  logic [31:0] o_arg[$];  logic [2:0] o_rt[$];  logic o_den[$];
  logic [5:0]  e_op[$];  logic [31:0] e_arg[$];  logic [2:0] e_rt[$];  logic e_den[$];
  int n_clr, n_start, first_clr, first_start, done_c;
  logic [2:0] last_res, last_ret;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_err(input logic [15:0] s);
    return (|s[13:8]) || (|s[5:0]);
  endfunction

  function automatic bit is_rdy(input logic [31:0] r);
    return r[8] && (r[12:9] == 4'd4);
  endfunction

  task automatic set_req(input logic [5:0] op, input logic [31:0] arg, input logic [2:0] rt,
                         input logic den, input logic rwn, input logic quad, input logic [9:0] bs,
                         input logic [7:0] bn, input logic poll, input logic [15:0] rca);
    bus.req_op_i = op;  bus.req_arg_i = arg;  bus.req_rsp_type_i = rt;
    bus.req_data_en_i = den;  bus.req_rwn_i = rwn;  bus.req_quad_i = quad;
    bus.req_block_size_i = bs;  bus.req_block_num_i = bn;
    bus.req_poll_en_i = poll;  bus.req_rca_i = rca;
  endtask

  task automatic fill_script(input int dly, input logic [15:0] st, input logic [31:0] rsp);
    for (int i = 0; i < NSC; i++) begin
      sc_dly[i] = dly; sc_st[i] = st; sc_rsp[i] = rsp;
    end
  endtask

  // Transaction-level expectation: command list, result, retries and done cycle
  // (cycles counted from the cycle the request is presented).
  task automatic model(output int res, output int ret, output int done_t);
    int t, k, d;
    t = 2; k = 0; d = 0; res = -1; ret = 0; done_t = -1;
    e_op.delete(); e_arg.delete(); e_rt.delete(); e_den.delete();
    for (int att = 0; att <= MAX_RETRY && res < 0; att++) begin
      e_op.push_back(bus.req_op_i); e_arg.push_back(bus.req_arg_i);
      e_rt.push_back(bus.req_rsp_type_i); e_den.push_back(bus.req_data_en_i);
      d = sc_dly[k];
      if (d == 0 || d > TMO) begin res = 2; done_t = t + TMO + 1; end
      else if (is_err(sc_st[k])) begin
        if (att < MAX_RETRY) begin ret++; t = t + d + 3; end
        else begin res = 1; done_t = t + d + 2; end
      end else begin
        res = 0; done_t = t + d + 2;
        if (bus.req_poll_en_i && bus.req_data_en_i && !bus.req_rwn_i) res = 9;
      end
      k++;
    end
    if (res == 9) begin
      res = -1;
      t = t + d + 3;
      for (int p = 0; p < POLL_MAX && res < 0; p++) begin
        e_op.push_back(6'd13); e_arg.push_back({bus.req_rca_i, 16'h0000});
        e_rt.push_back(3'd1); e_den.push_back(1'b0);
        d = sc_dly[k];
        if (d == 0 || d > TMO) begin res = 2; done_t = t + TMO + 1; end
        else if (is_err(sc_st[k])) begin res = 1; done_t = t + d + 2; end
        else if (is_rdy(sc_rsp[k])) begin res = 0; done_t = t + d + 2; end
        else if (p == POLL_MAX - 1) begin res = 3; done_t = t + d + 2; end
        else t = t + d + 3;
        k++;
      end
    end
  endtask

  // Present the request, play the engine from the script, then compare to the model.
  task automatic run_xfer(input string tag);
    int c, k, cur, eot_at, x_res, x_ret, x_done;
    c = 0; k = 0; cur = 0; eot_at = -1;
    n_clr = 0; n_start = 0; first_clr = -1; first_start = -1; done_c = -1;
    o_op.delete(); o_arg.delete(); o_rt.delete(); o_den.delete();
    bus.req_valid_i = 1'b1;
    while (done_c < 0 && c < 2000) begin
      @(negedge clk);
      c++;
      bus.req_valid_i = 1'b0;
      bus.eot_i = 1'b0;
      if (bus.clr_stat_o) begin n_clr++; if (first_clr < 0) first_clr = c; end
      if (bus.cmd_start_o) begin
        n_start++;
        if (first_start < 0) first_start = c;
        o_op.push_back(bus.cmd_op_o); o_arg.push_back(bus.cmd_arg_o);
        o_rt.push_back(bus.cmd_rsp_type_o); o_den.push_back(bus.data_en_o);
        cur = (k < NSC) ? k : NSC - 1;
        eot_at = (sc_dly[cur] > 0) ? c + sc_dly[cur] : -1;
        k++;
      end
      if (bus.done_o) done_c = c;
      if (c == eot_at) begin
        bus.eot_i = 1'b1; bus.status_i = sc_st[cur]; bus.rsp_data_i = sc_rsp[cur];
        eot_at = -1;
      end
    end
    bus.eot_i = 1'b0;
    chk({tag, "_done_seen"}, 64'(done_c >= 0), 64'd1);
    @(negedge clk);
    model(x_res, x_ret, x_done);
    last_res = bus.result_o;
    last_ret = bus.retries_o;
    chk({tag, "_ready_after"}, bus.req_ready_o, 1);
    chk({tag, "_busy_after"}, bus.busy_o, 0);
    chk({tag, "_result"}, bus.result_o, x_res);
    chk({tag, "_retries"}, bus.retries_o, x_ret);
    chk({tag, "_n_start"}, n_start, e_op.size());
    chk({tag, "_n_clr"}, n_clr, e_op.size());
    chk({tag, "_first_clr"}, first_clr, 1);
    chk({tag, "_first_start"}, first_start, 2);
    chk({tag, "_done_cycle"}, done_c, x_done);
    for (int i = 0; i < e_op.size() && i < o_op.size(); i++) begin
      chk($sformatf("%s_op%0d", tag, i), o_op[i], e_op[i]);
      chk($sformatf("%s_arg%0d", tag, i), o_arg[i], e_arg[i]);
      chk($sformatf("%s_rt%0d", tag, i), o_rt[i], e_rt[i]);
      chk($sformatf("%s_den%0d", tag, i), o_den[i], e_den[i]);
    end
  endtask

  initial begin
    int pulses;
    bus.req_valid_i = 1'b0; bus.eot_i = 1'b0; bus.status_i = '0; bus.rsp_data_i = '0;
    set_req(6'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 10'd0, 8'd0, 1'b0, 16'd0);
    repeat (3) @(negedge clk);
    chk("reset_ready", bus.req_ready_o, 1);
    chk("reset_busy", bus.busy_o, 0);
    chk("reset_pulses", {bus.clr_stat_o, bus.cmd_start_o, bus.done_o}, 0);
    chk("reset_result", {bus.result_o, bus.retries_o}, 0);
    chk("reset_cmd", {bus.cmd_op_o, bus.cmd_arg_o, bus.data_en_o}, 0);
    rst = 1'b0;
    @(negedge clk);

    // CMD0, no data, eot 10 cycles after start
    set_req(6'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 10'd0, 8'd0, 1'b0, 16'd0);
    fill_script(10, 16'h0000, 32'h0);
    run_xfer("cmd0");
    chk("cmd0_done_lat", done_c - first_start, 12);

    // read 4 blocks: data CRC error on two attempts, clean third
    set_req(6'd18, 32'h0000_0800, 3'd1, 1'b1, 1'b1, 1'b1, 10'd512, 8'd4, 1'b0, 16'h0);
    fill_script(7, 16'h0000, 32'h0);
    sc_st[0] = 16'h0100; sc_st[1] = 16'h0100;
    run_xfer("read4");
    chk("read4_retries_direct", last_ret, 2);

    // persistent command error: 1 + MAX_RETRY attempts
    set_req(6'd17, 32'h0000_0010, 3'd1, 1'b1, 1'b1, 1'b0, 10'd512, 8'd1, 1'b0, 16'h0);
    fill_script(5, 16'h0001, 32'h0);
    run_xfer("perr");
    chk("perr_starts_direct", n_start, 4);
    chk("perr_result_direct", last_res, 1);

    // eot never arrives
    fill_script(0, 16'h0000, 32'h0);
    run_xfer("tmo");
    chk("tmo_done_lat", done_c - first_start, TMO + 1);

    // eot exactly on the terminal count wins; one cycle later times out
    fill_script(TMO, 16'h0000, 32'h0);
    run_xfer("edge_ok");
    fill_script(TMO + 1, 16'h0000, 32'h0);
    run_xfer("edge_late");

    // polled write, card busy twice then ready in TRAN
    set_req(6'd24, 32'h0000_2000, 3'd1, 1'b1, 1'b0, 1'b1, 10'd512, 8'd1, 1'b1, 16'h1234);
    fill_script(4, 16'h0000, 32'h0000_0E00);
    sc_rsp[3] = 32'h0000_0900;
    run_xfer("poll_ok");
    chk("poll_ok_starts_direct", n_start, 4);

    // card never ready: POLL_MAX polls then busy timeout
    fill_script(3, 16'h0000, 32'h0000_0E00);
    run_xfer("poll_busy");
    chk("poll_busy_result_direct", last_res, 3);

    // reset while waiting for eot
    set_req(6'd25, 32'h0000_4000, 3'd1, 1'b1, 1'b0, 1'b0, 10'd512, 8'd2, 1'b0, 16'h1);
    fill_script(0, 16'h0000, 32'h0);
    bus.req_valid_i = 1'b1;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_pre_busy", bus.busy_o, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", bus.req_ready_o, 1);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_result", {bus.result_o, bus.retries_o}, 0);
    chk("rst_cmd_op", bus.cmd_op_o, 0);
    rst = 1'b0;
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done_o || bus.cmd_start_o || bus.clr_stat_o) pulses++;
    end
    chk("rst_no_pulse", pulses, 0);

    // randomized transfers
    for (int i = 0; i < 40; i++) begin
      set_req(6'($urandom), $urandom, 3'($urandom), 1'($urandom_range(0, 3) != 0),
              1'($urandom), 1'($urandom), 10'($urandom), 8'($urandom), 1'($urandom),
              16'($urandom));
      for (int j = 0; j < NSC; j++) begin
        case ($urandom_range(0, 19))
          0:       sc_dly[j] = 0;
          1:       sc_dly[j] = TMO + 1;
          2:       sc_dly[j] = TMO;
          default: sc_dly[j] = $urandom_range(1, 12);
        endcase
        sc_st[j] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : (16'($urandom) & 16'hC0C0);
        sc_rsp[j] = ($urandom_range(0, 2) == 0) ? (($urandom & 32'hFFFF_E0FF) | 32'h0000_0900)
                                                 : $urandom;
      end
      run_xfer($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
